// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer: keypad entry while idle, one-second decrement while mag_on.
// Optional expiry beeper enabled by defining DONE_BEEP_EN.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BEEP_SECS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       beep
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [15:0]   time_q;
  logic          tick;
  logic          key_ok;

  // Saturating BCD decrement of {min_tens,min_ones,sec_tens,sec_ones}; 00:00 stays put.
  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (t == 16'h0000) return t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'd9;
    end else begin
      st = 4'd5;
      so = 4'd9;
      if (mo != 4'd0) begin
        mo = mo - 4'd1;
      end else begin
        mt = mt - 4'd1;
        mo = 4'd9;
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign tick   = mag_on && (presc == PRESC_MAX);
  assign key_ok = key_valid && (key_code <= 4'd9) && !mag_on;

  always_ff @(posedge clk) begin
    if (reset || !clearn) begin
      time_q <= 16'h0000;
      presc  <= '0;
    end else begin
      if (key_ok) begin
        time_q <= {time_q[11:0], key_code};
      end else if (tick) begin
        time_q <= dec_time(time_q);
      end
      // Held at zero while idle so every start or resume runs a full second.
      if (!mag_on || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = time_q;
  assign timer_done = (time_q == 16'h0000);

`ifdef DONE_BEEP_EN
  localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);

  logic          beep_q;
  logic [PW-1:0] beep_presc;
  logic [BW-1:0] beep_sec;
  logic          expire;

  // Only a running decrement from 00:01 starts the beeper; a clear to 00:00 never does.
  assign expire = tick && (time_q == 16'h0001);

  always_ff @(posedge clk) begin
    if (reset || !clearn || key_ok) begin
      beep_q     <= 1'b0;
      beep_presc <= '0;
      beep_sec   <= '0;
    end else if (expire) begin
      beep_q     <= 1'b1;
      beep_presc <= '0;
      beep_sec   <= '0;
    end else if (beep_q) begin
      if (beep_presc == PRESC_MAX) begin
        beep_presc <= '0;
        if (beep_sec == BEEP_LAST) begin
          beep_q <= 1'b0;
        end else begin
          beep_sec <= beep_sec + BW'(1);
        end
      end else begin
        beep_presc <= beep_presc + PW'(1);
      end
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a queue scoreboard (TICKS_PER_SEC=4, BEEP_SECS=3).
module tb_countdown_timer;

`ifdef DONE_BEEP_EN
  localparam bit HAS_BEEP = 1'b1;
`else
  localparam bit HAS_BEEP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clearn = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       mag_on = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, beep;

  countdown_timer #(.TICKS_PER_SEC(4), .BEEP_SECS(3)) dut (
    .clk(clk), .reset(reset), .clearn(clearn), .key_valid(key_valid),
    .key_code(key_code), .mag_on(mag_on), .min_tens(min_tens),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .timer_done(timer_done), .beep(beep)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [17:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [15:0] t,
                              input logic done, input logic bp);
    exp_t e;
    e.tag = tag;
    e.val = {t, done, bp & HAS_BEEP};
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t        e;
    logic [17:0] obs;
    e   = sb.pop_front();
    obs = {min_tens, min_ones, sec_tens, sec_ones, timer_done, beep};
    n_assert++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed time=%h done=%b beep=%b, expected time=%h done=%b beep=%b",
             e.tag, obs[17:2], obs[1], obs[0], e.val[17:2], e.val[1], e.val[0]);
    end
  endtask

  task automatic run_check(input int n, input string tag, input logic [15:0] t,
                           input logic done, input logic bp);
    expect_state(tag, t, done, bp);
    step(n);
    check_front();
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    run_check(2, "reset", 16'h0000, 1'b1, 1'b0);
    reset = 1'b0;

    // Entry, invalid code, entry while running
    press(4'd1); press(4'd3);
    expect_state("key_13", 16'h0013, 1'b0, 1'b0); check_front();
    press(4'd0);
    expect_state("key_130", 16'h0130, 1'b0, 1'b0); check_front();
    press(4'd12);
    expect_state("key_invalid", 16'h0130, 1'b0, 1'b0); check_front();
    mag_on = 1'b1;
    press(4'd5);
    mag_on = 1'b0;
    expect_state("key_mag_on", 16'h0130, 1'b0, 1'b0); check_front();

    // Shift discards old min_tens
    press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    expect_state("key_shift", 16'h2345, 1'b0, 1'b0); check_front();

    // Expiry from 00:02
    clear_pulse();
    expect_state("clear_idle", 16'h0000, 1'b1, 1'b0); check_front();
    press(4'd2);
    mag_on = 1'b1;
    run_check(3, "pre_tick", 16'h0002, 1'b0, 1'b0);
    run_check(1, "tick_0001", 16'h0001, 1'b0, 1'b0);
    run_check(4, "expire", 16'h0000, 1'b1, 1'b1);
    run_check(4, "saturate", 16'h0000, 1'b1, 1'b1);
    mag_on = 1'b0;
    run_check(7, "beep_hold", 16'h0000, 1'b1, 1'b1);
    run_check(1, "beep_end", 16'h0000, 1'b1, 1'b0);

    // 01:00 -> 00:59, pause, resume
    press(4'd1); press(4'd0); press(4'd0);
    mag_on = 1'b1;
    run_check(4, "borrow_min", 16'h0059, 1'b0, 1'b0);
    mag_on = 1'b0;
    run_check(10, "pause_hold", 16'h0059, 1'b0, 1'b0);
    mag_on = 1'b1;
    run_check(3, "resume_pre", 16'h0059, 1'b0, 1'b0);
    run_check(1, "resume_tick", 16'h0058, 1'b0, 1'b0);
    run_check(52, "run_to_45", 16'h0045, 1'b0, 1'b0);

    // clearn while running
    clear_pulse();
    expect_state("clear_run", 16'h0000, 1'b1, 1'b0); check_front();
    run_check(8, "clear_no_beep", 16'h0000, 1'b1, 1'b0);
    mag_on = 1'b0;

    // Key press cuts the beep short
    press(4'd1);
    mag_on = 1'b1;
    run_check(4, "expire2", 16'h0000, 1'b1, 1'b1);
    mag_on = 1'b0;
    run_check(2, "beep2_hold", 16'h0000, 1'b1, 1'b1);
    press(4'd7);
    expect_state("key_kills_beep", 16'h0007, 1'b0, 1'b0); check_front();

    // 10:00 -> 09:59 and 01:90 -> 01:89
    clear_pulse();
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    mag_on = 1'b1;
    run_check(4, "borrow_tens_min", 16'h0959, 1'b0, 1'b0);
    mag_on = 1'b0;
    clear_pulse();
    press(4'd1); press(4'd9); press(4'd0);
    mag_on = 1'b1;
    run_check(4, "sec_tens_gt5", 16'h0189, 1'b0, 1'b0);
    mag_on = 1'b0;

    // Reset mid-run
    mag_on = 1'b1;
    step(2);
    reset = 1'b1;
    run_check(1, "reset_run", 16'h0000, 1'b1, 1'b0);
    reset = 1'b0;
    mag_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
